// File: rtl/gumnut_seq_ctrl.sv
// rtl/gumnut_seq_ctrl.sv - multicycle control sequencer for the Gumnut core
module gumnut_seq_ctrl #(
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1,
    parameter bit IE_RST      = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clk_en_i,
    input  logic [6:0] op_i,
    input  logic [2:0] func_i,
    input  logic       z_i,
    input  logic       c_i,
    input  logic       inst_ack_i,
    input  logic       data_ack_i,
    input  logic       int_req_i,
    output logic       inst_cyc_o,
    output logic       inst_stb_o,
    output logic       data_cyc_o,
    output logic       data_stb_o,
    output logic       data_we_o,
    output logic       port_o,
    output logic       ir_load_o,
    output logic       pc_en_o,
    output logic [1:0] pc_sel_o,
    output logic       alu_en_o,
    output logic       flag_we_o,
    output logic       reg_wr_o,
    output logic [3:0] alu_op_o,
    output logic [1:0] reg_mux_o,
    output logic       op2_sel_o,
    output logic       push_o,
    output logic       pop_o,
    output logic       int_ack_o,
    output logic       ie_o,
    output logic       stby_o,
    output logic       bus_err_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_INT    = 3'd5,
        S_WAIT   = 3'd6,
        S_ERR    = 3'd7
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    state_e           state_q, state_d, next_st;
    logic             ie_q, ie_d;
    logic             stby_q, stby_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic is_alu_imm, is_shift, is_alu_reg, is_mem, is_jump, is_branch, is_misc;
    logic br_taken, timeout_hit;

    assign is_alu_imm = ~op_i[6];
    assign is_shift   = (op_i[6:4] == 3'b110);
    assign is_alu_reg = (op_i[6:3] == 4'b1110);
    assign is_mem     = (op_i[6:5] == 2'b10);
    assign is_jump    = (op_i[6:2] == 5'b11110);
    assign is_branch  = (op_i[6:1] == 6'b111110);
    assign is_misc    = (op_i == 7'b1111110);

    always_comb begin
        br_taken = 1'b0;
        case (func_i[1:0])
            2'b00:   br_taken = z_i;
            2'b01:   br_taken = ~z_i;
            2'b10:   br_taken = c_i;
            default: br_taken = ~c_i;
        endcase
    end

    assign timeout_hit = (ACK_TIMEOUT > 0) && (cnt_q == CNT_LAST);

    // The interrupt decision at a Next point must see the ie written this cycle.
    always_comb begin
        ie_d = ie_q;
        if (state_q == S_DECODE && is_misc) begin
            case (func_i)
                3'd1, 3'd2: ie_d = 1'b1;
                3'd3:       ie_d = 1'b0;
                default:    ie_d = ie_q;
            endcase
        end else if (state_q == S_INT) begin
            ie_d = 1'b0;
        end
    end

    assign next_st = (int_req_i && ie_d) ? S_INT : S_FETCH;

    always_comb begin
        cnt_d = '0;
        if ((state_q == S_FETCH && !inst_ack_i) || (state_q == S_MEM && !data_ack_i)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        stby_d     = stby_q;
        inst_cyc_o = 1'b0;
        inst_stb_o = 1'b0;
        data_cyc_o = 1'b0;
        data_stb_o = 1'b0;
        data_we_o  = 1'b0;
        port_o     = 1'b0;
        ir_load_o  = 1'b0;
        pc_en_o    = 1'b0;
        pc_sel_o   = 2'd0;
        alu_en_o   = 1'b0;
        flag_we_o  = 1'b0;
        reg_wr_o   = 1'b0;
        alu_op_o   = 4'd0;
        reg_mux_o  = 2'd0;
        op2_sel_o  = 1'b0;
        push_o     = 1'b0;
        pop_o      = 1'b0;
        int_ack_o  = 1'b0;
        stby_o     = 1'b0;
        bus_err_o  = 1'b0;
        case (state_q)
            S_FETCH: begin
                inst_cyc_o = 1'b1;
                inst_stb_o = 1'b1;
                if (inst_ack_i) begin
                    ir_load_o = 1'b1;
                    pc_en_o   = 1'b1;
                    state_d   = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_ERR;
                end
            end
            S_DECODE: begin
                if (is_branch) begin
                    pc_en_o  = br_taken;
                    pc_sel_o = br_taken ? 2'd1 : 2'd0;
                    state_d  = next_st;
                end else if (is_jump) begin
                    pc_en_o  = 1'b1;
                    pc_sel_o = 2'd1;
                    push_o   = op_i[1];
                    state_d  = next_st;
                end else if (is_misc) begin
                    case (func_i)
                        3'd0, 3'd1: begin
                            pop_o    = 1'b1;
                            pc_en_o  = 1'b1;
                            pc_sel_o = 2'd2;
                            state_d  = next_st;
                        end
                        3'd4, 3'd5: begin
                            stby_d  = (func_i == 3'd5);
                            state_d = S_WAIT;
                        end
                        default: state_d = next_st;
                    endcase
                end else if (is_alu_imm || is_shift || is_alu_reg || is_mem) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = next_st;
                end
            end
            S_EXEC: begin
                if (is_mem) begin
                    alu_en_o = 1'b1;
                    state_d  = S_MEM;
                end else begin
                    alu_en_o  = 1'b1;
                    flag_we_o = 1'b1;
                    reg_wr_o  = 1'b1;
                    op2_sel_o = op_i[6];
                    if (is_alu_imm)     alu_op_o = {1'b0, op_i[5:3]};
                    else if (is_shift)  alu_op_o = {1'b1, func_i};
                    else                alu_op_o = {1'b0, func_i};
                    state_d = next_st;
                end
            end
            S_MEM: begin
                data_cyc_o = 1'b1;
                data_stb_o = 1'b1;
                data_we_o  = op_i[3];
                port_o     = op_i[4];
                if (data_ack_i) begin
                    state_d = op_i[3] ? next_st : S_WB;
                end else if (timeout_hit) begin
                    state_d = S_ERR;
                end
            end
            S_WB: begin
                reg_wr_o  = 1'b1;
                reg_mux_o = op_i[4] ? 2'd2 : 2'd1;
                state_d   = next_st;
            end
            S_INT: begin
                int_ack_o = 1'b1;
                push_o    = 1'b1;
                pc_en_o   = 1'b1;
                pc_sel_o  = 2'd3;
                state_d   = S_FETCH;
            end
            S_WAIT: begin
                stby_o = stby_q;
                if (int_req_i) state_d = next_st;
            end
            default: begin
                bus_err_o = 1'b1;
            end
        endcase
        // With the clock enable low nothing advances, so no side-effect pulses may escape.
        if (!clk_en_i) begin
            ir_load_o = 1'b0;
            pc_en_o   = 1'b0;
            reg_wr_o  = 1'b0;
            flag_we_o = 1'b0;
            push_o    = 1'b0;
            pop_o     = 1'b0;
            int_ack_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
            ie_q    <= IE_RST;
            stby_q  <= 1'b0;
            cnt_q   <= '0;
        end else if (clk_en_i) begin
            state_q <= state_d;
            ie_q    <= ie_d;
            stby_q  <= stby_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ie_o    = ie_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_gumnut_seq_ctrl.sv
// tb/tb_gumnut_seq_ctrl.sv - self-checking bench for gumnut_seq_ctrl
module tb_gumnut_seq_ctrl;
    localparam int TO = 4;
    localparam int C_ALUI = 0, C_SHIFT = 1, C_ALUR = 2, C_MEM = 3;
    localparam int C_JUMP = 4, C_BRANCH = 5, C_MISC = 6, C_UNDEF = 7;
    localparam logic [6:0] OPR = 7'b1110101, OPI = 7'b0101000, OPL = 7'b1000000;
    localparam logic [6:0] OPO = 7'b1011000, OPB = 7'b1111100, OPJ = 7'b1111010;
    localparam logic [6:0] OPM = 7'b1111110;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, z, c, iack, dack, irq;
    logic [6:0] op;
    logic [2:0] func;
    logic       inst_cyc_o, inst_stb_o, data_cyc_o, data_stb_o, data_we_o, port_o;
    logic       ir_load_o, pc_en_o, alu_en_o, flag_we_o, reg_wr_o, op2_sel_o;
    logic       push_o, pop_o, int_ack_o, ie_o, stby_o, bus_err_o;
    logic [1:0] pc_sel_o, reg_mux_o;
    logic [3:0] alu_op_o;
    logic [2:0] state_o;

    gumnut_seq_ctrl #(.ACK_TIMEOUT(TO), .IE_RST(1'b0)) dut (
        .clk_i(clk), .rst_i(rst), .clk_en_i(en), .op_i(op), .func_i(func),
        .z_i(z), .c_i(c), .inst_ack_i(iack), .data_ack_i(dack), .int_req_i(irq),
        .inst_cyc_o(inst_cyc_o), .inst_stb_o(inst_stb_o), .data_cyc_o(data_cyc_o),
        .data_stb_o(data_stb_o), .data_we_o(data_we_o), .port_o(port_o),
        .ir_load_o(ir_load_o), .pc_en_o(pc_en_o), .pc_sel_o(pc_sel_o),
        .alu_en_o(alu_en_o), .flag_we_o(flag_we_o), .reg_wr_o(reg_wr_o),
        .alu_op_o(alu_op_o), .reg_mux_o(reg_mux_o), .op2_sel_o(op2_sel_o),
        .push_o(push_o), .pop_o(pop_o), .int_ack_o(int_ack_o), .ie_o(ie_o),
        .stby_o(stby_o), .bus_err_o(bus_err_o), .state_o(state_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: phase number, interrupt enable, consecutive unacked bus cycles, standby entry.
    int m_st = 0, m_nst;
    bit m_ie = 1'b0, m_nie;
    int m_wait = 0, m_nwait;
    bit m_stby = 1'b0, m_nstby;
    bit m_valid = 1'b0;

    function automatic int cls_of(input logic [6:0] o);
        casez (o)
            7'b0??????: return C_ALUI;
            7'b10?????: return C_MEM;
            7'b110????: return C_SHIFT;
            7'b1110???: return C_ALUR;
            7'b11110??: return C_JUMP;
            7'b111110?: return C_BRANCH;
            7'b1111110: return C_MISC;
            default:    return C_UNDEF;
        endcase
    endfunction

    task automatic model(output logic [28:0] e);
        logic       icyc, dcyc, we, prt, irl, pcen, alue, fwe, rwr, op2, psh, pp, ack, sb, err;
        logic [1:0] pcsel, rmux;
        logic [3:0] aluop, conds;
        int         cls, go;
        bit         taken;
        {icyc, dcyc, we, prt, irl, pcen, alue, fwe, rwr, op2, psh, pp, ack, sb, err} = '0;
        pcsel = 2'd0; rmux = 2'd0; aluop = 4'd0;
        cls = cls_of(op);
        conds = {~c, c, ~z, z};
        taken = conds[func[1:0]];
        m_nie = m_ie;
        if (m_st == 1 && cls == C_MISC && (func == 3'd1 || func == 3'd2)) m_nie = 1'b1;
        if (m_st == 1 && cls == C_MISC && func == 3'd3) m_nie = 1'b0;
        if (m_st == 5) m_nie = 1'b0;
        go = (irq && m_nie) ? 5 : 0;
        m_nst = m_st; m_nwait = 0; m_nstby = m_stby;
        if (m_st == 0) begin
            icyc = 1'b1;
            if (iack) begin irl = 1'b1; pcen = 1'b1; m_nst = 1; end
            else begin m_nwait = m_wait + 1; if (m_nwait == TO) m_nst = 7; end
        end else if (m_st == 1) begin
            m_nst = go;
            if (cls == C_BRANCH && taken) begin pcen = 1'b1; pcsel = 2'd1; end
            if (cls == C_JUMP) begin pcen = 1'b1; pcsel = 2'd1; psh = op[1]; end
            if (cls == C_MISC && func <= 3'd1) begin pp = 1'b1; pcen = 1'b1; pcsel = 2'd2; end
            if (cls == C_MISC && (func == 3'd4 || func == 3'd5)) begin m_nst = 6; m_nstby = (func == 3'd5); end
            if (cls <= C_MEM) m_nst = 2;
        end else if (m_st == 2) begin
            alue = 1'b1;
            if (cls == C_MEM) m_nst = 3;
            else begin
                fwe = 1'b1; rwr = 1'b1; op2 = op[6]; m_nst = go;
                aluop = (cls == C_ALUI) ? {1'b0, op[5:3]} : (cls == C_SHIFT) ? {1'b1, func} : {1'b0, func};
            end
        end else if (m_st == 3) begin
            dcyc = 1'b1; we = op[3]; prt = op[4];
            if (dack) m_nst = we ? go : 4;
            else begin m_nwait = m_wait + 1; if (m_nwait == TO) m_nst = 7; end
        end else if (m_st == 4) begin
            rwr = 1'b1; rmux = op[4] ? 2'd2 : 2'd1; m_nst = go;
        end else if (m_st == 5) begin
            ack = 1'b1; psh = 1'b1; pcen = 1'b1; pcsel = 2'd3; m_nst = 0;
        end else if (m_st == 6) begin
            sb = m_stby;
            if (irq) m_nst = go;
        end else begin
            err = 1'b1;
        end
        if (!en) {irl, pcen, rwr, fwe, psh, pp, ack} = '0;
        e = {icyc, icyc, dcyc, dcyc, we, prt, irl, pcen, pcsel, alue, fwe, rwr, aluop, rmux,
             op2, psh, pp, ack, m_ie, sb, err, 3'(m_st)};
    endtask

    task automatic step(input bit r, input bit e, input logic [6:0] o, input logic [2:0] f,
                        input bit zz, input bit cc, input bit ia, input bit da, input bit iq);
        logic [28:0] ex, ac;
        @(posedge clk);
        #1;
        rst = r; en = e; op = o; func = f; z = zz; c = cc; iack = ia; dack = da; irq = iq;
        #3;
        model(ex);
        ac = {inst_cyc_o, inst_stb_o, data_cyc_o, data_stb_o, data_we_o, port_o, ir_load_o,
              pc_en_o, pc_sel_o, alu_en_o, flag_we_o, reg_wr_o, alu_op_o, reg_mux_o, op2_sel_o,
              push_o, pop_o, int_ack_o, ie_o, stby_o, bus_err_o, state_o};
        if (m_valid) begin
            n_checks++;
            if (ac !== ex) $display("FAIL cycle_model t=%0t actual=%b required=%b", $time, ac, ex);
            else n_pass++;
        end
        if (r) begin
            m_st = 0; m_ie = 1'b0; m_wait = 0; m_stby = 1'b0; m_valid = 1'b1;
        end else if (e) begin
            m_st = m_nst; m_ie = m_nie; m_wait = m_nwait; m_stby = m_nstby;
        end
    endtask

    task automatic run(input logic [6:0] o, input logic [2:0] f, input bit ia, input bit da, input bit iq);
        step(1'b0, 1'b1, o, f, 1'b0, 1'b0, ia, da, iq);
    endtask

    task automatic lit(input string name, input logic [3:0] act, input logic [3:0] req);
        n_checks++;
        if (act !== req) $display("FAIL %s actual=%0h required=%0h", name, act, req);
        else n_pass++;
    endtask

    logic [6:0] rop;
    logic [2:0] rf;
    int         k;

    initial begin
        rst = 1'b1; en = 1'b1; op = '0; func = '0; z = 1'b0; c = 1'b0;
        iack = 1'b0; dack = 1'b0; irq = 1'b0;
        step(1, 1, OPR, 3'd2, 0, 0, 0, 0, 0);
        step(1, 1, OPR, 3'd2, 0, 0, 0, 0, 0);
        lit("reset_state", state_o, 0); lit("reset_ie", ie_o, 0); lit("reset_err", bus_err_o, 0);
        // fetch with three wait cycles; the ack lands on the last counted cycle
        for (int i = 0; i < 3; i++) begin run(OPR, 3'd2, 0, 0, 0); lit("fetch_cyc", inst_cyc_o, 1); end
        run(OPR, 3'd2, 1, 0, 0);
        lit("fetch_irl", ir_load_o, 1); lit("fetch_pcen", pc_en_o, 1); lit("fetch_pcsel", pc_sel_o, 0);
        run(OPR, 3'd2, 0, 0, 0); lit("decode_state", state_o, 1);
        run(OPR, 3'd2, 0, 0, 0);
        lit("alur_op", alu_op_o, 4'b0010); lit("alur_fwe", flag_we_o, 1); lit("alur_rwr", reg_wr_o, 1);
        lit("alur_mux", reg_mux_o, 0);
        run(OPR, 3'd2, 0, 0, 0); lit("alur_back", state_o, 0);
        // ldm with two data wait cycles
        run(OPL, 3'd0, 1, 0, 0); run(OPL, 3'd0, 0, 0, 0);
        run(OPL, 3'd0, 0, 0, 0); lit("mem_addr_op", alu_op_o, 0); lit("mem_alu_en", alu_en_o, 1);
        for (int i = 0; i < 2; i++) begin
            run(OPL, 3'd0, 0, 0, 0); lit("ldm_cyc", data_cyc_o, 1); lit("ldm_we", data_we_o, 0);
        end
        run(OPL, 3'd0, 0, 1, 0); lit("ldm_cyc_ack", data_cyc_o, 1);
        run(OPL, 3'd0, 0, 0, 0); lit("wb_mux", reg_mux_o, 1); lit("wb_state", state_o, 4);
        // out: write to port, no writeback
        run(OPO, 3'd0, 1, 0, 0); run(OPO, 3'd0, 0, 0, 0); run(OPO, 3'd0, 0, 0, 0);
        run(OPO, 3'd0, 0, 1, 0); lit("out_we", data_we_o, 1); lit("out_port", port_o, 1);
        run(OPO, 3'd0, 0, 0, 0); lit("out_nowb", state_o, 0);
        // branches and jsb
        run(OPB, 3'd0, 1, 0, 0); run(OPB, 3'd0, 0, 0, 0); lit("bz_nt_pcen", pc_en_o, 0);
        run(OPB, 3'd1, 1, 0, 0); run(OPB, 3'd1, 0, 0, 0);
        lit("bnz_pcen", pc_en_o, 1); lit("bnz_pcsel", pc_sel_o, 1);
        run(OPJ, 3'd0, 1, 0, 0); run(OPJ, 3'd0, 0, 0, 0); lit("jsb_push", push_o, 1);
        // enai, then interrupt during an ALU-immediate op
        run(OPM, 3'd2, 1, 0, 0); run(OPM, 3'd2, 0, 0, 0);
        run(OPI, 3'd0, 1, 0, 0); lit("enai_ie", ie_o, 1);
        run(OPI, 3'd0, 0, 0, 0);
        run(OPI, 3'd0, 0, 0, 1); lit("alui_op", alu_op_o, 4'b0101); lit("alui_op2", op2_sel_o, 0);
        run(OPI, 3'd0, 0, 0, 0);
        lit("int_state", state_o, 5); lit("int_ack", int_ack_o, 1); lit("int_pcsel", pc_sel_o, 3);
        run(OPM, 3'd1, 0, 0, 0); lit("int_ie_clr", ie_o, 0);
        run(OPM, 3'd1, 1, 0, 0); run(OPM, 3'd1, 0, 0, 0);
        lit("reti_pop", pop_o, 1); lit("reti_pcsel", pc_sel_o, 2);
        run(OPM, 3'd3, 1, 0, 0); lit("reti_ie", ie_o, 1);
        // disi with a pending request: the cleared ie must be used
        run(OPM, 3'd3, 0, 0, 1);
        run(OPM, 3'd5, 1, 0, 1); lit("disi_no_int", state_o, 0);
        // standby
        run(OPM, 3'd5, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            run(OPM, 3'd5, 0, 0, 0); lit("stby_on", stby_o, 1); lit("wait_pcen", pc_en_o, 0);
        end
        run(OPM, 3'd5, 0, 0, 1);
        run(OPR, 3'd2, 0, 0, 0); lit("stby_exit", state_o, 0); lit("stby_off", stby_o, 0);
        // clock enable low freezes and blocks pulses
        for (int i = 0; i < 2; i++) begin
            step(0, 0, OPR, 3'd2, 0, 0, 1, 0, 0);
            lit("en_irl", ir_load_o, 0); lit("en_cyc", inst_cyc_o, 1);
        end
        run(OPR, 3'd2, 1, 0, 0); lit("en_resume", ir_load_o, 1);
        run(OPR, 3'd2, 0, 0, 0); run(OPR, 3'd2, 0, 0, 0);
        // data timeout to sticky error
        run(OPL, 3'd0, 1, 0, 0); run(OPL, 3'd0, 0, 0, 0); run(OPL, 3'd0, 0, 0, 0);
        for (int i = 0; i < TO; i++) run(OPL, 3'd0, 0, 0, 0);
        run(OPL, 3'd0, 1, 1, 0);
        lit("err_state", state_o, 7); lit("err_flag", bus_err_o, 1); lit("err_nocyc", data_cyc_o, 0);
        run(OPL, 3'd0, 1, 1, 1); lit("err_sticky", bus_err_o, 1);
        step(1, 1, OPL, 3'd0, 0, 0, 0, 0, 0);
        run(OPL, 3'd0, 0, 0, 0); lit("err_cleared", bus_err_o, 0);
        // randomized traffic
        rop = OPR; rf = 3'd0;
        for (int i = 0; i < 4000; i++) begin
            if (m_st == 0) begin
                k = $urandom_range(0, 7);
                case (k)
                    0:       rop = {1'b0, 6'($urandom)};
                    1:       rop = {3'b110, 4'($urandom)};
                    2:       rop = {4'b1110, 3'($urandom)};
                    3:       rop = {2'b10, 5'($urandom)};
                    4:       rop = {5'b11110, 2'($urandom)};
                    5:       rop = {6'b111110, 1'($urandom)};
                    6:       rop = 7'b1111110;
                    default: rop = 7'b1111111;
                endcase
                rf = 3'($urandom);
            end
            step((m_st == 7) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 299) == 0),
                 $urandom_range(0, 9) != 0, rop, rf,
                 1'($urandom), 1'($urandom),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 5) == 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/gumnut_seq_ctrl.md
Name: gumnut_seq_ctrl

Overview:
Parametrised multicycle sequencer for the Gumnut core: next generation of the core control unit.
- Decodes the 7-bit opcode/3-bit func and drives PC, ALU, register bank, stack and interrupt controls.
- Runs Wishbone-style instruction and data handshakes.
- Adds bus-ack timeout with a sticky error state, interrupt-enable tracking, and wait/standby parking.

Parameters:
ACK_TIMEOUT, 16, cycles without ack before bus error; 0 disables the timeout.
CNT_W, $clog2(ACK_TIMEOUT+1), timeout counter width.
IE_RST, 0, reset value of the interrupt-enable flag.

Ports:
clk_i in 1 clock
rst_i in 1 synchronous active-high reset
clk_en_i in 1 clock enable; low = all state/counters hold, pulse outputs forced 0
op_i in 7 opcode from instruction register
func_i in 3 function field
z_i, c_i in 1 each zero/carry flags
inst_ack_i in 1 instruction bus ack
data_ack_i in 1 data/port bus ack
int_req_i in 1 level interrupt request
inst_cyc_o, inst_stb_o out 1 instruction bus cycle/strobe
data_cyc_o, data_stb_o, data_we_o out 1 data bus cycle/strobe/write
port_o out 1 1 = IO port cycle (inp/out), 0 = memory
ir_load_o out 1 capture instruction
pc_en_o out 1 PC update
pc_sel_o out 2 0 PC+1, 1 target, 2 stack pop, 3 int vector
alu_en_o, flag_we_o, reg_wr_o out 1 ALU enable, Z/C write, register write
alu_op_o out 4 ALU op
reg_mux_o out 2 0 ALU, 1 memory, 2 port
op2_sel_o out 1 1 = rs2, 0 = immediate
push_o, pop_o out 1 return-stack push/pop
int_ack_o out 1 interrupt ack pulse
ie_o out 1 interrupt enable
stby_o out 1 standby indicator
bus_err_o out 1 sticky bus timeout
state_o out 3 current state

Behaviour:
- Outputs are combinational from the registered state plus op_i/func_i; unlisted outputs are 0.
- Decode classes:
  - op_i[6]=0: ALU-immediate.
  - op_i[6:4]=110: shift.
  - op_i[6:3]=1110: ALU-register.
  - op_i[6:5]=10: mem; op_i[4:3]: 00 ldm, 01 stm, 10 inp, 11 out.
  - op_i[6:2]=11110: jump; op_i[1]=1 is jsb.
  - op_i[6:1]=111110: branch; op_i[0] unused; func_i[1:0]: 00 bz, 01 bnz, 10 bc, 11 bnc.
  - op_i=1111110: misc; func_i: 0 ret, 1 reti, 2 enai, 3 disi, 4 wait, 5 stby.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, INT=5, WAIT=6, ERR=7.
- "Next" = INT if int_req_i&ie, else FETCH.
- Reset: state FETCH, ie=IE_RST, bus_err_o=0, counter 0. Reset mid-handshake drops cyc/stb on the following cycle; the bus is restarted from FETCH.
- FETCH:
  - inst_cyc_o=inst_stb_o=1, held until ack.
  - On inst_ack_i: ir_load_o=1, pc_en_o=1, pc_sel_o=0 -> DECODE.
- DECODE:
  - branch: if taken, pc_en_o=1, pc_sel_o=1 -> Next.
  - jump: pc_en_o=1, pc_sel_o=1; jsb also push_o=1 -> Next.
  - ret: pop_o, pc_en_o, pc_sel_o=2 -> Next.
  - reti: same as ret plus ie<=1.
  - enai: ie<=1 -> Next.
  - disi: ie<=0 -> Next. Evaluate Next with the updated ie.
  - wait/stby -> WAIT.
  - Undefined misc func: no-op -> Next.
  - ALU/shift/mem -> EXEC.
- EXEC:
  - ALU: alu_en_o, flag_we_o, reg_wr_o, reg_mux_o=0 -> Next.
  - alu_op_o={0,func_i} for register form, {0,op_i[5:3]} for immediate form, {1,func_i} for shift.
  - op2_sel_o=op_i[6] for ALU forms.
  - mem: alu_en_o=1, alu_op_o=0000 (address add), op2_sel_o=0 -> MEM.
- MEM:
  - data_cyc_o=data_stb_o=1; data_we_o=1 for stm/out; port_o=op_i[4].
  - On data_ack_i: ldm/inp -> WB; stm/out -> Next.
- WB: reg_wr_o=1, reg_mux_o = 1 (ldm) / 2 (inp) -> Next.
- INT: int_ack_o=1, push_o=1, pc_en_o=1, pc_sel_o=3, ie<=0 -> FETCH. Exactly one cycle.
- WAIT:
  - stby_o=1 if entered via stby.
  - Holds until int_req_i=1, then INT if ie, else FETCH.
  - PC is not advanced in WAIT.
- Timeout:
  - Counter resets on state entry and on ack; increments each enabled cycle in FETCH/MEM without ack.
  - When the count reaches ACK_TIMEOUT (ACK_TIMEOUT>0), the state goes to ERR.
  - An ack arriving in that same cycle wins over the timeout.
- ERR: bus_err_o=1, all strobes 0, state stays ERR until reset.
- clk_en_i=0: state/ie/counter frozen, pulse outputs (ir_load, pc_en, reg_wr, flag_we, push, pop, int_ack) 0, cyc/stb keep their levels.
- Interrupt is only taken at Next points; an int_req_i pulse that drops before a Next point is lost.

Test Plan:
- Reset, inst_ack_i held 0 for 3 cycles then 1 -> inst_cyc_o/inst_stb_o=1 for 4 cycles; on the ack cycle ir_load_o=1, pc_en_o=1, pc_sel_o=0; then state_o=1.
- op_i=1110xxx func_i=010 -> EXEC: alu_op_o=0010, flag_we_o=1, reg_wr_o=1, reg_mux_o=0; back in FETCH 3 cycles after the fetch ack.
- ldm with data_ack_i after 2 wait cycles -> data_cyc_o high 3 cycles, data_we_o=0; WB reg_mux_o=1. out -> data_we_o=1, port_o=1, no WB.
- bz with z_i=0 -> pc_en_o=0 in DECODE. bnz with z_i=0 -> pc_en_o=1, pc_sel_o=1. jsb -> push_o=1.
- enai, then int_req_i=1 during an ALU op -> INT after EXEC: int_ack_o one cycle, pc_sel_o=3, ie_o falls to 0. reti -> pop_o=1, ie_o=1.
- ACK_TIMEOUT=4, data_ack_i never asserted -> ERR after 4 MEM cycles: bus_err_o=1 and sticky until rst_i. stby -> stby_o=1 until int_req_i.
